// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bundle for the bit-serial subtractor.
// The requester drives the master side; the subtractor implements the slave side.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, LSB first, one bit per clock through
// a single full-subtractor cell and a borrow flop. The result appears only when DONE is entered.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_subtractor_if.slave bus
);
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shreg_a_reg, shreg_b_reg;
  logic [WIDTH-1:0] res_reg, res_next;
  logic [WIDTH-1:0] diff_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             borrow_reg, borrow_next;
  logic             borrow_out_reg;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             x_bit, y_bit, d_bit, last_bit;

  // Full-subtractor cell on the current LSBs of the operand registers.
  assign x_bit       = shreg_a_reg[0];
  assign y_bit       = shreg_b_reg[0];
  assign d_bit       = x_bit ^ y_bit ^ borrow_reg;
  assign borrow_next = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & borrow_reg);
  assign last_bit    = (cnt_reg == CNT_W'(WIDTH - 1));

  // Result enters at the MSB and walks down, so the first bit lands at bit 0 after WIDTH shifts.
  generate
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_res_shift
      assign res_next[gi] = res_reg[gi+1];
    end
  endgenerate
  assign res_next[WIDTH-1] = d_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = SHIFT;
      SHIFT:   if (last_bit)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Flags are decoded from the upcoming state so they can be registered alongside it.
  always_comb begin
    busy_next = (state_next != IDLE);
    done_next = (state_next == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_a_reg    <= '0;
      shreg_b_reg    <= '0;
      res_reg        <= '0;
      diff_reg       <= '0;
      cnt_reg        <= '0;
      borrow_reg     <= 1'b0;
      borrow_out_reg <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      busy_reg <= busy_next;
      done_reg <= done_next;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            shreg_a_reg <= bus.a;
            shreg_b_reg <= bus.b;
            borrow_reg  <= 1'b0;
            cnt_reg     <= '0;
          end
        end
        SHIFT: begin
          shreg_a_reg <= shreg_a_reg >> 1;
          shreg_b_reg <= shreg_b_reg >> 1;
          res_reg     <= res_next;
          borrow_reg  <= borrow_next;
          cnt_reg     <= cnt_reg + CNT_W'(1);
          if (last_bit) begin
            diff_reg       <= res_next;
            borrow_out_reg <= borrow_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy       = busy_reg;
  assign bus.done       = done_reg;
  assign bus.diff       = diff_reg;
  assign bus.borrow_out = borrow_out_reg;
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed vector table, re-trigger, async reset,
// start-held-high streaming and random operations against an arithmetic reference model.
module tb_serial_subtractor;
  localparam int WIDTH = 8;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] exp_diff;
    logic             exp_borrow;
    int               retrig;
  } vec_t;

  vec_t table_v[6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: plain modular subtraction and an unsigned compare.
  function automatic logic [WIDTH-1:0] ref_diff(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    return WIDTH'((x - y) & ((1 << WIDTH) - 1));
  endfunction

  function automatic logic ref_borrow(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    return (x < y);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation; retrig >= 0 pulses start with 1-1 at that many cycles after acceptance.
  task automatic run_op(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b,
                        input int retrig, input string tag);
    int               lat;
    int               busy_cnt;
    logic             held;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] exp_d;
    logic             exp_bo;
    exp_d     = ref_diff(op_a, op_b);
    exp_bo    = ref_borrow(op_a, op_b);
    bus.a     = op_a;
    bus.b     = op_b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.a     = WIDTH'($urandom);
    bus.b     = WIDTH'($urandom);
    prev      = bus.diff;
    lat       = 0;
    busy_cnt  = 0;
    held      = 1'b1;
    while (!bus.done && lat < 40) begin
      if (bus.busy) busy_cnt++;
      if (bus.diff !== prev) held = 1'b0;
      if (lat == retrig) begin
        bus.start = 1'b1;
        bus.a     = 8'h01;
        bus.b     = 8'h01;
      end else begin
        bus.start = 1'b0;
      end
      tick();
      lat++;
    end
    bus.start = 1'b0;
    if (bus.busy) busy_cnt++;
    check({tag, "_latency"}, 32'(lat), 32'(WIDTH));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(WIDTH + 1));
    check({tag, "_diff_held"}, {31'd0, held}, 32'd1);
    check({tag, "_diff"}, 32'(bus.diff), 32'(exp_d));
    check({tag, "_borrow"}, {31'd0, bus.borrow_out}, {31'd0, exp_bo});
    $display("op %s: a=%02h b=%02h -> diff=%02h borrow=%0b latency=%0d", tag, op_a, op_b,
             bus.diff, bus.borrow_out, lat);
    tick();
    check({tag, "_after_done"}, {30'd0, bus.busy, bus.done}, 32'd0);
    check({tag, "_diff_hold_idle"}, 32'(bus.diff), 32'(exp_d));
  endtask

  initial begin
    logic [WIDTH-1:0] pa[$];
    logic [WIDTH-1:0] pb[$];
    logic             seen_done;
    logic             hold_ok;
    logic [WIDTH-1:0] last_diff;
    int               k;
    int               cyc;
    int               last_cyc;
    int               n_stream;

    vectors     = 0;
    miscompares = 0;
    table_v[0]  = '{8'h5A, 8'h3C, 8'h1E, 1'b0, -1};
    table_v[1]  = '{8'h00, 8'h01, 8'hFF, 1'b1, -1};
    table_v[2]  = '{8'hFF, 8'hFF, 8'h00, 1'b0, -1};
    table_v[3]  = '{8'h80, 8'h7F, 8'h01, 1'b0, -1};
    table_v[4]  = '{8'h10, 8'h20, 8'hF0, 1'b1, 3};
    table_v[5]  = '{8'h01, 8'hFF, 8'h02, 1'b1, -1};

    rst_n     = 1'b0;
    bus.start = 1'b1;
    bus.a     = 8'hAA;
    bus.b     = 8'h55;
    repeat (3) tick();
    check("reset_outputs", {22'd0, bus.busy, bus.done, bus.borrow_out, bus.diff}, 32'd0);
    bus.start = 1'b0;
    #2 rst_n = 1'b1;
    tick();

    // Directed table; the expected columns are hand-derived, the model cross-checks them.
    for (int i = 0; i < 6; i++) begin
      check($sformatf("table%0d_model", i), {23'd0, ref_borrow(table_v[i].a, table_v[i].b),
            ref_diff(table_v[i].a, table_v[i].b)}, {23'd0, table_v[i].exp_borrow, table_v[i].exp_diff});
      run_op(table_v[i].a, table_v[i].b, table_v[i].retrig, $sformatf("table%0d", i));
    end

    // Asynchronous reset in the middle of an operation.
    bus.a     = 8'h33;
    bus.b     = 8'h11;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    check("midop_reset_async", {22'd0, bus.busy, bus.done, bus.borrow_out, bus.diff}, 32'd0);
    tick();
    #1 rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done || bus.busy) seen_done = 1'b1;
    end
    check("midop_reset_no_done", {31'd0, seen_done}, 32'd0);
    $display("op reset: aborted mid-operation, outputs cleared");
    run_op(8'h9C, 8'h27, -1, "post_reset");

    // start held high: a new random pair is accepted every WIDTH+2 cycles.
    n_stream = 12;
    for (int i = 0; i < n_stream; i++) begin
      pa.push_back(WIDTH'($urandom));
      pb.push_back((i % 2 == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 3)));
    end
    k         = 0;
    cyc       = 0;
    last_cyc  = 0;
    hold_ok   = 1'b1;
    last_diff = bus.diff;
    bus.a     = pa[0];
    bus.b     = pb[0];
    bus.start = 1'b1;
    while (k < n_stream && cyc < n_stream * (WIDTH + 2) + 40) begin
      tick();
      cyc++;
      if (bus.done) begin
        check($sformatf("stream%0d_diff", k), 32'(bus.diff), 32'(ref_diff(pa[k], pb[k])));
        check($sformatf("stream%0d_borrow", k), {31'd0, bus.borrow_out}, {31'd0, ref_borrow(pa[k], pb[k])});
        if (k > 0) check($sformatf("stream%0d_period", k), 32'(cyc - last_cyc), 32'(WIDTH + 2));
        $display("op stream%0d: a=%02h b=%02h -> diff=%02h borrow=%0b", k, pa[k], pb[k],
                 bus.diff, bus.borrow_out);
        last_cyc  = cyc;
        last_diff = bus.diff;
        k++;
        if (k < n_stream) begin
          bus.a = pa[k];
          bus.b = pb[k];
        end
      end else if (bus.diff !== last_diff) begin
        hold_ok = 1'b0;
      end
    end
    bus.start = 1'b0;
    check("stream_count", 32'(k), 32'(n_stream));
    check("stream_diff_hold", {31'd0, hold_ok}, 32'd1);
    repeat (WIDTH + 4) tick();

    // Random single operations, some with a stray start during the operation.
    for (int i = 0; i < 12; i++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom), (i % 3 == 0) ? int'($urandom_range(0, WIDTH)) : -1,
             $sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial unsigned subtractor: diff = a - b, computed LSB-first, one bit per clock, through a single full-subtractor cell and a borrow flip-flop.
- It is the inverse-direction companion to the team's gate-level adder blocks. It is the first clocked arithmetic unit for the event-driven simulator test suite.
- It exercises sequential state, a start/done handshake and multi-cycle latency, in contrast to the purely combinational adder netlists.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepting edge.
- b  input  WIDTH  subtrahend; captured on the accepting edge.
- busy  output  1  high while in SHIFT or DONE.
- done  output  1  one-cycle pulse; diff and borrow_out are valid.
- diff  output  WIDTH  result a - b mod 2^WIDTH.
- borrow_out  output  1  final borrow; 1 iff a < b (unsigned).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - Operand shift registers, bit counter, borrow flop and result shift register cleared.
  - busy=0, done=0, diff=0, borrow_out=0.
  - Release is synchronous to the next clk edge.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - If start=1 at an edge: capture a into shreg_a and b into shreg_b; set borrow=0 and cnt=0; go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, at each edge:
  - Take bit x=shreg_a[0] and y=shreg_b[0].
  - d = x ^ y ^ borrow.
  - borrow_next = (~x & y) | (~(x ^ y) & borrow).
  - Shift d into the result register MSB-first, so that after WIDTH shifts the LSB sits at bit 0.
  - Shift both operand registers right by 1 and increment cnt.
  - On the edge where cnt == WIDTH-1: load diff from the completed result register and borrow_out from borrow_next, then go to DONE.
- DONE: done=1 for exactly this one cycle; the next edge returns to IDLE unconditionally.
- Latency:
  - start sampled at edge E0.
  - WIDTH SHIFT edges, E1..E_WIDTH.
  - done high in the cycle after E_WIDTH.
  - Next start accepted no earlier than edge E_WIDTH+2.
- busy:
  - Registered.
  - High from the cycle after E0 through the DONE cycle inclusive.
  - Low in IDLE.
- diff/borrow_out:
  - Change only on entry to DONE.
  - Hold their value through IDLE and the next operation until the next DONE. Intermediate bits are never visible.
- start while busy=1 (SHIFT or DONE): ignored, no queuing. Operands on a/b are don't-care after E0.
- start held high continuously: a new operation is accepted on each IDLE edge, i.e. every WIDTH+2 cycles.
- Wrap-around: diff is modulo 2^WIDTH; borrow_out carries the sign information. No saturation.
- Reset mid-operation: abort immediately. All outputs go to their reset values and the partial result is discarded.
- Reset takes priority over start at the same edge.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, start pulse → done exactly 9 cycles after the start edge; diff=0x1E, borrow_out=0; busy high for 9 cycles.
- a=0x00, b=0x01 → diff=0xFF, borrow_out=1.
- Edge-value check, 0xFF-0xFF and 0x80-0x7F:
  - a=0xFF, b=0xFF → diff=0x00, borrow_out=0.
  - a=0x80, b=0x7F → diff=0x01, borrow_out=0.
- Re-trigger during an operation:
  - Start op a=0x10, b=0x20.
  - Pulse start with a=0x01, b=0x01 at cycle 4.
  - Required: ignored; single done with diff=0xF0, borrow_out=1.
- Assert rst_n=0 at cycle 5 of an operation → busy=0, done=0, diff=0, borrow_out=0 immediately (asynchronous, no clock edge needed); no done pulse follows; a fresh start after release gives a correct result.
- start tied high with alternating operand pairs → done every 10 cycles; each result matches the pair present at its accepting edge; diff holds between done pulses.
